// File: rtl/jtag_dtm_tap.sv
// JTAG Debug Transport Module: oversampled IEEE 1149.1 TAP whose DR scans are
// bridged to a DMI request/response handshake, all on the system clock.
module jtag_dtm_tap #(
  parameter logic [31:0] IDCODE    = 32'h00000001,
  parameter int          ABITS     = 7,
  parameter logic [2:0]  IDLE_HINT = 3'd5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             jtag_TCK,
  input  logic             jtag_TMS,
  input  logic             jtag_TDI,
  input  logic             jtag_TRSTn,
  output logic             jtag_TDO_data,
  output logic             jtag_TDO_driven,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_resp_valid,
  output logic             dmi_resp_ready,
  input  logic [31:0]      dmi_resp_data,
  input  logic [1:0]       dmi_resp_resp,
  output logic [3:0]       tap_state
);

  localparam int         DMI_W       = ABITS + 34;
  localparam logic [4:0] IR_IDCODE   = 5'h01;
  localparam logic [4:0] IR_DTMCS    = 5'h10;
  localparam logic [4:0] IR_DMI      = 5'h11;
  localparam logic [5:0] ABITS_FIELD = 6'(ABITS);

  typedef enum logic [3:0] {
    TLR        = 4'd0,
    RTI        = 4'd1,
    SELECT_DR  = 4'd2,
    CAPTURE_DR = 4'd3,
    SHIFT_DR   = 4'd4,
    EXIT1_DR   = 4'd5,
    PAUSE_DR   = 4'd6,
    EXIT2_DR   = 4'd7,
    UPDATE_DR  = 4'd8,
    SELECT_IR  = 4'd9,
    CAPTURE_IR = 4'd10,
    SHIFT_IR   = 4'd11,
    EXIT1_IR   = 4'd12,
    PAUSE_IR   = 4'd13,
    EXIT2_IR   = 4'd14,
    UPDATE_IR  = 4'd15
  } tap_e;

  tap_e             state;
  logic             tck_meta, tck_s, tck_d;
  logic             tms_meta, tms_s;
  logic             tdi_meta, tdi_s;
  logic             trstn_meta, trstn_s;
  logic             rise, fall;
  logic [4:0]       ir, ir_shift;
  logic [31:0]      dr32_shift;
  logic [DMI_W-1:0] dmi_shift;
  logic             bypass_shift;
  logic             sticky_busy, outstanding, failed;
  logic [31:0]      resp_data_reg;
  logic [ABITS-1:0] addr_reg;
  logic [1:0]       op_status;
  logic [31:0]      dtmcs_value;
  logic             tdo_bit;
  logic [ABITS-1:0] upd_addr;
  logic [31:0]      upd_data;
  logic [1:0]       upd_op;

  function automatic tap_e next_state(tap_e s, logic tms);
    tap_e n;
    case (s)
      TLR:        n = tms ? TLR       : RTI;
      RTI:        n = tms ? SELECT_DR : RTI;
      SELECT_DR:  n = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR: n = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:   n = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:   n = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:   n = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:   n = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:  n = tms ? SELECT_DR : RTI;
      SELECT_IR:  n = tms ? TLR       : CAPTURE_IR;
      CAPTURE_IR: n = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:   n = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:   n = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:   n = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:   n = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:  n = tms ? SELECT_DR : RTI;
      default:    n = TLR;
    endcase
    return n;
  endfunction

  assign rise      = tck_s & ~tck_d;
  assign fall      = ~tck_s & tck_d;
  assign tap_state = state;
  assign upd_addr  = dmi_shift[DMI_W-1:34];
  assign upd_data  = dmi_shift[33:2];
  assign upd_op    = dmi_shift[1:0];

  // Two-flop synchronizers for the JTAG pins plus the delayed TCK for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      tck_meta   <= 1'b0;
      tck_s      <= 1'b0;
      tck_d      <= 1'b0;
      tms_meta   <= 1'b0;
      tms_s      <= 1'b0;
      tdi_meta   <= 1'b0;
      tdi_s      <= 1'b0;
      trstn_meta <= 1'b0;
      trstn_s    <= 1'b0;
    end else begin
      tck_meta   <= jtag_TCK;
      tck_s      <= tck_meta;
      tck_d      <= tck_s;
      tms_meta   <= jtag_TMS;
      tms_s      <= tms_meta;
      tdi_meta   <= jtag_TDI;
      tdi_s      <= tdi_meta;
      trstn_meta <= jtag_TRSTn;
      trstn_s    <= trstn_meta;
    end
  end

  // Status reported by a DMI capture; busy wins over a stale failure
  always_comb begin
    op_status = 2'd0;
    if (sticky_busy || outstanding) begin
      op_status = 2'd3;
    end else if (failed) begin
      op_status = 2'd2;
    end else begin
      op_status = 2'd0;
    end
  end

  // DTMCS capture image: version 1, address width, busy status and idle hint
  always_comb begin
    dtmcs_value = {17'd0, IDLE_HINT, (sticky_busy ? 2'd3 : 2'd0), ABITS_FIELD, 4'd1};
  end

  // LSB of whichever shift register the current TAP branch is using
  always_comb begin
    tdo_bit = bypass_shift;
    if (state inside {CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR}) begin
      tdo_bit = ir_shift[0];
    end else begin
      case (ir)
        IR_IDCODE, IR_DTMCS: tdo_bit = dr32_shift[0];
        IR_DMI:              tdo_bit = dmi_shift[0];
        default:             tdo_bit = bypass_shift;
      endcase
    end
  end

  // TAP controller, scan registers and DMI handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= TLR;
      ir              <= IR_IDCODE;
      ir_shift        <= 5'd0;
      dr32_shift      <= 32'd0;
      dmi_shift       <= '0;
      bypass_shift    <= 1'b0;
      jtag_TDO_data   <= 1'b0;
      jtag_TDO_driven <= 1'b0;
      sticky_busy     <= 1'b0;
      outstanding     <= 1'b0;
      failed          <= 1'b0;
      resp_data_reg   <= 32'd0;
      addr_reg        <= '0;
      dmi_req_valid   <= 1'b0;
      dmi_req_addr    <= '0;
      dmi_req_data    <= 32'd0;
      dmi_req_op      <= 2'd0;
      dmi_resp_ready  <= 1'b0;
    end else begin
      if (dmi_req_valid && dmi_req_ready) begin
        dmi_req_valid  <= 1'b0;
        dmi_resp_ready <= 1'b1;
      end
      if (dmi_resp_ready && dmi_resp_valid) begin
        resp_data_reg  <= dmi_resp_data;
        failed         <= (dmi_resp_resp != 2'd0);
        outstanding    <= 1'b0;
        dmi_resp_ready <= 1'b0;
      end

      // Test reset leaves an accepted transaction free to complete
      if (!trstn_s) begin
        state           <= TLR;
        ir              <= IR_IDCODE;
        ir_shift        <= 5'd0;
        dr32_shift      <= 32'd0;
        dmi_shift       <= '0;
        bypass_shift    <= 1'b0;
        jtag_TDO_data   <= 1'b0;
        jtag_TDO_driven <= 1'b0;
        sticky_busy     <= 1'b0;
        addr_reg        <= '0;
        dmi_req_valid   <= 1'b0;
      end else begin
        if (rise) begin
          case (state)
            CAPTURE_DR: begin
              case (ir)
                IR_IDCODE: dr32_shift <= IDCODE | 32'h00000001;
                IR_DTMCS:  dr32_shift <= dtmcs_value;
                IR_DMI: begin
                  dmi_shift <= {addr_reg, resp_data_reg, op_status};
                  if (sticky_busy || outstanding) begin
                    sticky_busy <= 1'b1;
                  end
                end
                default:   bypass_shift <= 1'b0;
              endcase
            end
            SHIFT_DR: begin
              case (ir)
                IR_IDCODE, IR_DTMCS: dr32_shift <= {tdi_s, dr32_shift[31:1]};
                IR_DMI:              dmi_shift  <= {tdi_s, dmi_shift[DMI_W-1:1]};
                default:             bypass_shift <= tdi_s;
              endcase
            end
            UPDATE_DR: begin
              case (ir)
                IR_DTMCS: begin
                  if (dr32_shift[16]) begin
                    sticky_busy <= 1'b0;
                  end
                end
                IR_DMI: begin
                  if (!sticky_busy && !outstanding &&
                      (upd_op == 2'd1 || upd_op == 2'd2)) begin
                    dmi_req_valid <= 1'b1;
                    dmi_req_addr  <= upd_addr;
                    dmi_req_data  <= upd_data;
                    dmi_req_op    <= upd_op;
                    outstanding   <= 1'b1;
                    addr_reg      <= upd_addr;
                  end
                end
                default: ;
              endcase
            end
            CAPTURE_IR: ir_shift <= 5'b00001;
            SHIFT_IR:   ir_shift <= {tdi_s, ir_shift[4:1]};
            UPDATE_IR:  ir       <= ir_shift;
            default: ;
          endcase
          state <= next_state(state, tms_s);
          if (next_state(state, tms_s) == TLR) begin
            ir <= IR_IDCODE;
          end
        end
        if (fall) begin
          jtag_TDO_data   <= tdo_bit;
          jtag_TDO_driven <= (state == SHIFT_IR) || (state == SHIFT_DR);
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_dtm_tap.sv
// Self-checking bench for jtag_dtm_tap: a bit-queue TAP/DMI model checked every
// clock, plus literal expectations for IDCODE, BYPASS, DTMCS and DMI status.
module tb_jtag_dtm_tap;
  localparam int ABITS = 7;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic jtag_TCK = 1'b0, jtag_TMS = 1'b0, jtag_TDI = 1'b0, jtag_TRSTn = 1'b1;
  logic jtag_TDO_data, jtag_TDO_driven;
  logic dmi_req_valid, dmi_req_ready = 1'b0;
  logic [ABITS-1:0] dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0] dmi_req_op;
  logic dmi_resp_valid = 1'b0, dmi_resp_ready;
  logic [31:0] dmi_resp_data = 32'd0;
  logic [1:0] dmi_resp_resp = 2'd0;
  logic [3:0] tap_state;

  jtag_dtm_tap dut (
    .clock(clock), .reset(reset),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
    .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
    .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
    .dmi_resp_data(dmi_resp_data), .dmi_resp_resp(dmi_resp_resp),
    .tap_state(tap_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  // TAP transition table indexed by state number: nx0 for TMS=0, nx1 for TMS=1
  int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int m_state, m_ir;
  bit q[$];
  bit m_sticky, m_out, m_failed;
  logic [31:0] m_resp;
  logic [6:0] m_addr;
  bit e_tdo, e_drv, e_rv, e_rr;
  logic [6:0] e_addr;
  logic [31:0] e_data;
  logic [1:0] e_op;

  logic [63:0] got;
  int gotn;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic q_load(logic [63:0] v, int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(v[i]);
  endtask

  function automatic logic [63:0] q_value();
    logic [63:0] r = 64'd0;
    foreach (q[i]) r[i] = q[i];
    return r;
  endfunction

  task automatic m_reset(bit full);
    m_state = 0; m_ir = 1; e_tdo = 1'b0; e_drv = 1'b0;
    q.delete(); m_sticky = 1'b0; e_rv = 1'b0; m_addr = 7'd0;
    if (full) begin
      e_rr = 1'b0; m_out = 1'b0; m_failed = 1'b0; m_resp = 32'd0;
    end
  endtask

  task automatic m_capture_dr();
    int st;
    if (m_ir == 1) q_load(64'h1, 32);
    else if (m_ir == 16) q_load(64'(1 + 7 * 16 + (m_sticky ? 3 : 0) * 1024 + 5 * 4096), 32);
    else if (m_ir == 17) begin
      st = (m_sticky || m_out) ? 3 : (m_failed ? 2 : 0);
      if (m_sticky || m_out) m_sticky = 1'b1;
      q_load(64'(st) + (64'(m_resp) << 2) + (64'(m_addr) << 34), 41);
    end else q_load(64'h0, 1);
  endtask

  task automatic m_update_dr();
    logic [63:0] v = q_value();
    if (m_ir == 16 && v[16]) m_sticky = 1'b0;
    if (m_ir == 17 && !m_sticky && !m_out && (v[1:0] == 2'd1 || v[1:0] == 2'd2)) begin
      e_rv = 1'b1; e_addr = v[40:34]; e_data = v[33:2]; e_op = v[1:0];
      m_out = 1'b1; m_addr = v[40:34];
    end
  endtask

  task automatic m_rise(bit tms, bit tdi);
    int cur = m_state;
    if (cur == 3) m_capture_dr();
    else if (cur == 4 || cur == 11) begin void'(q.pop_front()); q.push_back(tdi); end
    else if (cur == 8) m_update_dr();
    else if (cur == 10) q_load(64'h1, 5);
    else if (cur == 15) m_ir = int'(q_value());
    m_state = tms ? nx1[cur] : nx0[cur];
    if (m_state == 0) m_ir = 1;
  endtask

  task automatic m_fall();
    e_drv = (m_state == 4 || m_state == 11);
    if (e_drv) e_tdo = q[0];
  endtask

  // Every-cycle comparison of the DUT against the model
  always @(negedge clock) begin
    if (chk_on) begin
      check("tap_state", tap_state, m_state);
      check("tdo_driven", jtag_TDO_driven, e_drv);
      if (e_drv) check("tdo_data", jtag_TDO_data, e_tdo);
      check("req_valid", dmi_req_valid, e_rv);
      check("resp_ready", dmi_resp_ready, e_rr);
      if (e_rv) begin
        check("req_addr", dmi_req_addr, e_addr);
        check("req_data", dmi_req_data, e_data);
        check("req_op", dmi_req_op, e_op);
      end
    end
  end

  task automatic half(bit tck, bit tms, bit tdi);
    @(negedge clock);
    jtag_TCK = tck; jtag_TMS = tms; jtag_TDI = tdi;
    repeat (3) @(posedge clock);
    #1;
    if (tck) m_rise(tms, tdi);
    else m_fall();
  endtask

  task automatic clk(bit tms, bit tdi);
    half(1'b1, tms, tdi);
    half(1'b0, tms, tdi);
    if (jtag_TDO_driven && gotn < 64) begin
      got[gotn] = jtag_TDO_data;
      gotn++;
    end
  endtask

  task automatic dr_scan(int n, logic [63:0] din);
    got = 64'd0; gotn = 0;
    clk(1'b1, 1'b0); clk(1'b0, 1'b0); clk(1'b0, 1'b0);
    for (int i = 0; i < n; i++) clk(i == n - 1, din[i]);
    clk(1'b1, 1'b0); clk(1'b0, 1'b0);
  endtask

  task automatic ir_scan(logic [4:0] v);
    got = 64'd0; gotn = 0;
    clk(1'b1, 1'b0); clk(1'b1, 1'b0); clk(1'b0, 1'b0); clk(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) clk(i == 4, v[i]);
    clk(1'b1, 1'b0); clk(1'b0, 1'b0);
  endtask

  task automatic dmi_cycle(bit ready, bit rvalid, logic [31:0] rdata, logic [1:0] rresp);
    @(negedge clock);
    dmi_req_ready = ready; dmi_resp_valid = rvalid; dmi_resp_data = rdata; dmi_resp_resp = rresp;
    @(posedge clock);
    #1;
    if (e_rv && ready) begin
      e_rv = 1'b0; e_rr = 1'b1;
    end else if (e_rr && rvalid) begin
      m_resp = rdata; m_failed = (rresp != 2'd0); m_out = 1'b0; e_rr = 1'b0;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL timeout: run exceeded its time budget");
    $fatal(1);
  end

  initial begin
    logic [6:0] ra;
    logic [31:0] rd;
    logic [1:0] rop, rr;

    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    m_reset(1'b1);
    chk_on = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_state", tap_state, 4'd0);
    check("rst_driven", jtag_TDO_driven, 1'b0);
    check("rst_req_valid", dmi_req_valid, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(posedge clock);

    // Into Shift-DR, then five TMS=1 clocks return to Test-Logic-Reset
    clk(1'b0, 1'b0); clk(1'b1, 1'b0); clk(1'b0, 1'b0); clk(1'b0, 1'b0);
    check("in_shdr", tap_state, 4'd4);
    repeat (5) clk(1'b1, 1'b0);
    check("tms5_tlr", tap_state, 4'd0);

    clk(1'b0, 1'b0);
    dr_scan(32, 64'd0);
    check("idcode", got[31:0], 32'h00000001);
    check("idcode_len", gotn, 32);

    ir_scan(5'h1F);
    dr_scan(4, 64'b1101);
    check("bypass", got[3:0], 4'b1010);

    // DMI write with a stalled request channel
    ir_scan(5'h11);
    dr_scan(41, {23'd0, 7'h10, 32'hDEADBEEF, 2'd2});
    for (int i = 0; i < 4; i++) begin
      dmi_cycle(1'b0, 1'b0, 32'd0, 2'd0);
      check("hold_valid", dmi_req_valid, 1'b1);
      check("hold_addr", dmi_req_addr, 7'h10);
      check("hold_data", dmi_req_data, 32'hDEADBEEF);
      check("hold_op", dmi_req_op, 2'd2);
    end
    dmi_cycle(1'b1, 1'b0, 32'd0, 2'd0);
    check("accept_valid", dmi_req_valid, 1'b0);
    check("accept_rready", dmi_resp_ready, 1'b1);
    dmi_cycle(1'b0, 1'b0, 32'd0, 2'd0);
    dmi_cycle(1'b0, 1'b1, 32'hCAFE0001, 2'd0);
    dmi_cycle(1'b0, 1'b0, 32'd0, 2'd0);
    check("resp_done", dmi_resp_ready, 1'b0);
    dr_scan(41, 64'd0);
    check("dmi_op_ok", got[1:0], 2'd0);
    check("dmi_rdata", got[33:2], 32'hCAFE0001);
    check("dmi_addr", got[40:34], 7'h10);

    // Busy path: capture while outstanding, ignored update, dmireset
    dr_scan(41, {23'd0, 7'h22, 32'h12345678, 2'd1});
    dr_scan(41, {23'd0, 7'h05, 32'h0, 2'd2});
    check("dmi_busy", got[1:0], 2'd3);
    check("busy_keep_addr", dmi_req_addr, 7'h22);
    check("busy_keep_op", dmi_req_op, 2'd1);
    ir_scan(5'h10);
    dr_scan(32, 64'd0);
    check("dtmcs_busy", got[31:0], 32'h00005C71);
    dr_scan(32, 64'h10000);
    dr_scan(32, 64'd0);
    check("dtmcs_clear", got[31:0], 32'h00005071);
    dmi_cycle(1'b1, 1'b0, 32'd0, 2'd0);
    dmi_cycle(1'b0, 1'b1, 32'h00000BAD, 2'd2);
    dmi_cycle(1'b0, 1'b0, 32'd0, 2'd0);
    ir_scan(5'h11);
    dr_scan(41, 64'd0);
    check("dmi_failed", got[1:0], 2'd2);

    // Test reset in the middle of Shift-DR
    clk(1'b1, 1'b0); clk(1'b0, 1'b0); clk(1'b0, 1'b0);
    clk(1'b0, 1'b1); clk(1'b0, 1'b0);
    @(negedge clock);
    jtag_TRSTn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    m_reset(1'b0);
    check("trst_state", tap_state, 4'd0);
    check("trst_driven", jtag_TDO_driven, 1'b0);
    @(negedge clock);
    jtag_TRSTn = 1'b1;
    repeat (4) @(posedge clock);
    clk(1'b0, 1'b0);
    dr_scan(32, 64'd0);
    check("trst_ir_idcode", got[31:0], 32'h00000001);

    // Randomized DMI traffic
    for (int k = 0; k < 12; k++) begin
      ra = 7'($urandom); rd = $urandom; rop = 2'($urandom);
      ir_scan(5'h11);
      dr_scan(41, {23'd0, ra, rd, rop});
      if (m_out) begin
        if ($urandom_range(0, 2) == 0) begin
          ra = 7'($urandom); rd = $urandom; rop = 2'($urandom);
          dr_scan(41, {23'd0, ra, rd, rop});
          ir_scan(5'h10);
          dr_scan(32, 64'h10000);
        end
        repeat ($urandom_range(0, 5)) dmi_cycle(1'b0, 1'b0, 32'd0, 2'd0);
        dmi_cycle(1'b1, 1'b0, 32'd0, 2'd0);
        repeat ($urandom_range(0, 4)) dmi_cycle(1'b0, 1'b0, 32'd0, 2'd0);
        rd = $urandom;
        rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        dmi_cycle(1'b0, 1'b1, rd, rr);
        dmi_cycle(1'b0, 1'b0, 32'd0, 2'd0);
      end
    end

    repeat (2) @(posedge clock);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
